// File: rtl/down_counter_timer_if.sv
// Bus bundle for the down-counting timer: control strobes in, count/status out.
// With DOWN_COUNTER_TIMER_STICKY_EN defined it also carries clr_flag/tc_flag.
interface down_counter_timer_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             mode;
    logic             en;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             busy;
    logic             done;
`ifdef DOWN_COUNTER_TIMER_STICKY_EN
    logic             clr_flag;
    logic             tc_flag;
`endif

    modport master (
        output load,
        output load_val,
        output mode,
        output en,
        input  count,
        input  tc,
        input  busy,
        input  done
`ifdef DOWN_COUNTER_TIMER_STICKY_EN
        ,
        output clr_flag,
        input  tc_flag
`endif
    );

    modport slave (
        input  load,
        input  load_val,
        input  mode,
        input  en,
        output count,
        output tc,
        output busy,
        output done
`ifdef DOWN_COUNTER_TIMER_STICKY_EN
        ,
        input  clr_flag,
        output tc_flag
`endif
    );
endinterface

// File: rtl/down_counter_timer.sv
// Loadable down-counting timer (one-shot / periodic) updating on the falling edge.
// Optional sticky expiry flag enabled by defining DOWN_COUNTER_TIMER_STICKY_EN.
module down_counter_timer #(
    parameter int WIDTH = 4
) (
    input logic              clk,
    input logic              rst,
    down_counter_timer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic             tc_q, tc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             load_nz;
    logic             expire;

    assign load_nz = bus.load && (bus.load_val != ZERO);
    // An expiry only counts when no load competes with it on the same edge.
    assign expire  = !bus.load && (state_q == S_RUN) && bus.en && (count_q == ONE);

    // State register (all flops share the falling edge and async active-low reset)
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            count_q  <= ZERO;
            reload_q <= ZERO;
            mode_q   <= 1'b0;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            tc_q     <= tc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (bus.load) begin
            state_d = load_nz ? S_RUN : S_IDLE;
        end else if (expire && !mode_q) begin
            state_d = S_DONE;
        end
    end

    // Datapath and registered output decode
    always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        tc_d     = 1'b0;
        if (bus.load) begin
            count_d  = bus.load_val;
            reload_d = bus.load_val;
            if (load_nz) begin
                mode_d = bus.mode;
            end
        end else if (state_q == S_RUN && bus.en) begin
            if (expire) begin
                tc_d    = 1'b1;
                count_d = mode_q ? reload_q : ZERO;
            end else begin
                count_d = count_q - ONE;
            end
        end
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

`ifdef DOWN_COUNTER_TIMER_STICKY_EN
    logic tc_flag_q, tc_flag_d;

    // Set wins over clear when both land on the same edge.
    always_comb begin
        tc_flag_d = tc_flag_q;
        if (tc_d) begin
            tc_flag_d = 1'b1;
        end else if (bus.clr_flag) begin
            tc_flag_d = 1'b0;
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            tc_flag_q <= 1'b0;
        end else begin
            tc_flag_q <= tc_flag_d;
        end
    end

    assign bus.tc_flag = tc_flag_q;
`endif

endmodule
